// File: rtl/tx_buffer_writer_pkg.sv
`default_nettype none
//==============================================================================
// Module   : tx_buffer_writer_pkg
// Brief    : Shared constants, FSM encoding and header layout for the TX
//            frame buffer writer and its reader.
// Revision : 1.0 - initial release
//==============================================================================
package tx_buffer_writer_pkg;

    localparam int BUF_DEPTH   = 512;
    localparam int PTR_W       = 10;
    localparam int ADDR_W      = 9;
    localparam int HDR_LEN_MSB = 63;
    localparam int HDR_LEN_LSB = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_DROP   = 3'd2,
        ST_HDR    = 3'd3,
        ST_COMMIT = 3'd4
    } wr_state_t;

    // Distance of a pointer ahead of the reader, modulo the pointer space.
    function automatic ptr_t occ(input ptr_t p, input ptr_t rd_ptr);
        return p - rd_ptr;
    endfunction

    // Frame length in bytes from its qword count and the valid bytes of the last qword.
    function automatic logic [31:0] frame_bytes(input ptr_t qwords, input logic [2:0] last_bytes);
        logic [31:0] tail;
        tail = (last_bytes == 3'd0) ? 32'd8 : {29'd0, last_bytes};
        return {19'd0, qwords - 10'd1, 3'd0} + tail;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_buffer_writer.sv
`default_nettype none
//==============================================================================
// Module   : tx_buffer_writer
// Brief    : Writes host frames into the 512x64 TX buffer as header + payload
//            and publishes each complete frame by advancing the commit pointer.
// Revision : 1.0 - initial release
//==============================================================================
module tx_buffer_writer
    import tx_buffer_writer_pkg::*;
#(
    parameter int MIN_QWORDS = 8,
    parameter int MAX_QWORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [2:0]        in_last_bytes,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic [PTR_W-1:0]  commited_wr_addr,
    input  logic [PTR_W-1:0]  commited_rd_addr,
    output logic [15:0]       drop_count
);

    wr_state_t         r_state;
    ptr_t              r_hdr_ptr;
    ptr_t              r_cur_ptr;
    ptr_t              r_qcount;
    logic [31:0]       r_bytes;
    logic              r_live;

    wr_state_t         w_state_nxt;
    ptr_t              w_hdr_nxt;
    ptr_t              w_cur_nxt;
    ptr_t              w_qcount_nxt;
    logic [31:0]       w_bytes_nxt;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [63:0]       w_wr_data_nxt;
    ptr_t              w_commit_nxt;
    logic [15:0]       w_drop_nxt;

    ptr_t              w_base;
    ptr_t              w_first;
    ptr_t              w_second;
    ptr_t              w_qinc;
    ptr_t              w_cur_inc;
    logic              w_ready;
    logic              w_fire;
    logic              w_restart;
    logic [63:0]       w_hdr_word;

    // While idle the header slot tracks the commit pointer directly.
    assign w_base    = (r_state == ST_IDLE) ? commited_wr_addr : r_hdr_ptr;
    assign w_first   = w_base + 10'd1;
    assign w_second  = w_base + 10'd2;
    assign w_qinc    = r_qcount + 10'd1;
    assign w_cur_inc = r_cur_ptr + 10'd1;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = (occ(w_first, commited_rd_addr) < ptr_t'(BUF_DEPTH));
            ST_DATA: w_ready = (occ(r_cur_ptr, commited_rd_addr) < ptr_t'(BUF_DEPTH));
            ST_DROP: w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // r_live holds ready low from reset until the first clock edge after release.
    assign in_ready  = r_live & w_ready;
    assign w_fire    = in_valid & in_ready;
    // An eof beat while discarding closes the bad frame even if it carries sof.
    assign w_restart = in_sof & ~((r_state == ST_DROP) & in_eof);

    always_comb begin
        w_hdr_word = '0;
        w_hdr_word[HDR_LEN_MSB:HDR_LEN_LSB] = r_bytes;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_nxt     = r_hdr_ptr;
        w_cur_nxt     = r_cur_ptr;
        w_qcount_nxt  = r_qcount;
        w_bytes_nxt   = r_bytes;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = wr_addr;
        w_wr_data_nxt = wr_data;
        w_commit_nxt  = commited_wr_addr;
        w_drop_nxt    = drop_count;

        case (r_state)
            ST_IDLE, ST_DATA, ST_DROP: begin
                if (w_fire) begin
                    if (w_restart) begin
                        if (r_state != ST_IDLE) begin
                            w_drop_nxt = drop_count + 16'd1;
                        end
                        w_hdr_nxt     = w_base;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_first[ADDR_W-1:0];
                        w_wr_data_nxt = in_data;
                        w_cur_nxt     = w_second;
                        w_qcount_nxt  = 10'd1;
                        if (in_eof) begin
                            if (MIN_QWORDS <= 1) begin
                                w_bytes_nxt = frame_bytes(10'd1, in_last_bytes);
                                w_state_nxt = ST_HDR;
                            end else begin
                                w_drop_nxt  = w_drop_nxt + 16'd1;
                                w_state_nxt = ST_IDLE;
                            end
                        end else if (MAX_QWORDS == 1) begin
                            w_state_nxt = ST_DROP;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else if (r_state == ST_DATA) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_cur_ptr[ADDR_W-1:0];
                        w_wr_data_nxt = in_data;
                        w_cur_nxt     = w_cur_inc;
                        w_qcount_nxt  = w_qinc;
                        if (in_eof) begin
                            if (w_qinc < 10'(MIN_QWORDS)) begin
                                w_drop_nxt  = drop_count + 16'd1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_bytes_nxt = frame_bytes(w_qinc, in_last_bytes);
                                w_state_nxt = ST_HDR;
                            end
                        end else if (w_qinc == 10'(MAX_QWORDS)) begin
                            w_state_nxt = ST_DROP;
                        end
                    end else if ((r_state == ST_IDLE) || in_eof) begin
                        // Stray beat in IDLE, or the end of a frame being discarded.
                        w_drop_nxt  = drop_count + 16'd1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HDR: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_hdr_ptr[ADDR_W-1:0];
                w_wr_data_nxt = w_hdr_word;
                w_state_nxt   = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit_nxt = r_cur_ptr;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_hdr_ptr        <= '0;
            r_cur_ptr        <= '0;
            r_qcount         <= '0;
            r_bytes          <= '0;
            r_live           <= 1'b0;
            wr_en            <= 1'b0;
            wr_addr          <= '0;
            wr_data          <= '0;
            commited_wr_addr <= '0;
            drop_count       <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_hdr_ptr        <= w_hdr_nxt;
            r_cur_ptr        <= w_cur_nxt;
            r_qcount         <= w_qcount_nxt;
            r_bytes          <= w_bytes_nxt;
            r_live           <= 1'b1;
            wr_en            <= w_wr_en_nxt;
            wr_addr          <= w_wr_addr_nxt;
            wr_data          <= w_wr_data_nxt;
            commited_wr_addr <= w_commit_nxt;
            drop_count       <= w_drop_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_buffer_writer.sv
`default_nettype none
//==============================================================================
// Module   : tb_tx_buffer_writer
// Brief    : Frame-level reference model and directed/random stimulus for
//            tx_buffer_writer, checked every cycle on the falling edge.
// Revision : 1.0 - initial release
//==============================================================================
module tb_tx_buffer_writer;

    localparam int MIN_Q = 8;
    localparam int MAX_Q = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic [2:0]  in_last_bytes = '0;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  commited_wr_addr;
    logic [9:0]  rd = '0;
    logic [15:0] drop_count;

    tx_buffer_writer #(.MIN_QWORDS(MIN_Q), .MAX_QWORDS(MAX_Q)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_last_bytes(in_last_bytes),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commited_wr_addr(commited_wr_addr), .commited_rd_addr(rd),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_live, m_open, m_over, hdr_arm, cmt_arm;
    logic [9:0]  m_commit, m_hdr, m_pend;
    int          m_len;
    logic [31:0] m_bytes;
    logic        e_wr_en;
    logic [8:0]  e_wr_addr;
    logic [63:0] e_wr_data;
    logic [15:0] e_drop;

    logic [63:0] mem [512];
    int          wr_cnt = 0;
    int          wraps  = 0;
    logic [9:0]  prev_commit = '0;

    function automatic bit pred_ready();
        logic [9:0] slot;
        if (!m_live || hdr_arm || cmt_arm) return 1'b0;
        if (m_over) return 1'b1;
        slot = m_open ? (m_hdr + 10'd1 + 10'(m_len)) : (m_commit + 10'd1);
        return (10'(slot - rd) < 10'd512);
    endfunction

    task automatic model_reset();
        m_live = 0; m_open = 0; m_over = 0; hdr_arm = 0; cmt_arm = 0;
        m_commit = '0; m_hdr = '0; m_pend = '0; m_len = 0; m_bytes = '0;
        e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0; e_drop = '0;
    endtask

    task automatic take_payload();
        logic [9:0] slot;
        slot = m_hdr + 10'd1 + 10'(m_len);
        e_wr_en = 1; e_wr_addr = slot[8:0]; e_wr_data = in_data;
        m_len++;
        if (in_eof) begin
            m_open = 0;
            if (m_len < MIN_Q) e_drop++;
            else begin
                m_bytes = 32'((m_len - 1) * 8 + ((in_last_bytes == 0) ? 8 : int'(in_last_bytes)));
                m_pend  = m_hdr + 10'd1 + 10'(m_len);
                hdr_arm = 1;
            end
        end else if (m_len == MAX_Q) begin
            m_open = 0; m_over = 1;
        end
    endtask

    task automatic model_step(input bit fire);
        e_wr_en = 0;
        if (cmt_arm) begin m_commit = m_pend; cmt_arm = 0; end
        if (hdr_arm) begin
            e_wr_en = 1; e_wr_addr = m_hdr[8:0]; e_wr_data = {m_bytes, 32'h0};
            hdr_arm = 0; cmt_arm = 1;
        end
        if (fire) begin
            if (m_over && in_eof) begin e_drop++; m_over = 0; end
            else if (in_sof) begin
                if (m_open || m_over) e_drop++;
                m_open = 1; m_over = 0; m_hdr = m_commit; m_len = 0;
                take_payload();
            end
            else if (m_open) take_payload();
            else if (!m_over) e_drop++;
        end
        m_live = 1;
    endtask

    initial begin
        bit p;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            p = pred_ready();
            check("in_ready", in_ready, p);
            check("wr_en", wr_en, e_wr_en);
            if (e_wr_en || !reset_n) begin
                check("wr_addr", wr_addr, e_wr_addr);
                check("wr_data", wr_data, e_wr_data);
            end
            check("commit", commited_wr_addr, m_commit);
            check("drop", drop_count, e_drop);
            if (wr_en) begin mem[wr_addr] = wr_data; wr_cnt++; end
            if (commited_wr_addr < prev_commit) wraps++;
            prev_commit = commited_wr_addr;
            if (reset_n) model_step(in_valid && p);
        end
    end

    // ---------------- stimulus ----------------
    int gap_max = 1;
    bit rd_follow = 0;

    initial forever begin
        logic [9:0] d;
        @(posedge clk); #1;
        if (rd_follow) begin
            d = commited_wr_addr - rd;
            if (d != 0 && $urandom_range(0, 2) == 0) rd = rd + 10'($urandom_range(1, int'(d)));
        end
    end

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic send_beat(input logic [63:0] d, input bit sof, input bit eof,
                             input logic [2:0] lb, input int budget, output bit ok);
        bit r;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        in_valid = 1; in_data = d; in_sof = sof; in_eof = eof; in_last_bytes = lb;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        in_valid = 0; in_data = {$urandom, $urandom};
        in_sof = $urandom_range(0, 1); in_eof = $urandom_range(0, 1);
    endtask

    task automatic send_frame(input int n, input logic [2:0] lb, input string name);
        bit ok;
        for (int i = 0; i < n; i++) begin
            send_beat({$urandom, $urandom}, i == 0, i == n - 1, lb, 200, ok);
            if (!ok) check({name, "_timeout"}, 0, 1);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [63:0] sent [8];

    initial begin
        bit ok;
        int stalls, wr0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_commit", commited_wr_addr, 0);
        check("rst_drop", drop_count, 0);
        reset_n = 1;

        // 64-byte frame from reset
        for (int b = 0; b < 8; b++) begin
            sent[b] = {$urandom, $urandom};
            send_beat(sent[b], b == 0, b == 7, 3'd0, 50, ok);
            check("f64_accept", ok, 1);
        end
        check("f64_commit_t0", commited_wr_addr, 10'd0);
        wait_cycles(1);
        check("f64_commit_t1", commited_wr_addr, 10'd0);
        wait_cycles(1);
        check("f64_commit_t2", commited_wr_addr, 10'd9);
        check("f64_header", mem[0], 64'h00000040_00000000);
        for (int b = 0; b < 8; b++) check("f64_payload", mem[1 + b], sent[b]);

        // 61-byte frame
        send_frame(8, 3'd5, "f61");
        wait_cycles(2);
        check("f61_commit", commited_wr_addr, 10'd18);
        check("f61_header", mem[9], 64'h0000003D_00000000);

        // runt frame
        send_frame(3, 3'd0, "runt");
        wait_cycles(3);
        check("runt_drop", drop_count, 16'd1);
        check("runt_commit", commited_wr_addr, 10'd18);

        // oversize frame
        wr0 = wr_cnt;
        send_frame(300, 3'd0, "over");
        wait_cycles(3);
        check("over_writes", wr_cnt - wr0, 256);
        check("over_drop", drop_count, 16'd2);
        check("over_commit", commited_wr_addr, 10'd18);

        // sof mid-frame: first frame abandoned, second committed at slot 18
        for (int b = 0; b < 4; b++) begin
            send_beat({$urandom, $urandom}, b == 0, 0, 3'd0, 50, ok);
        end
        send_frame(8, 3'd0, "restart");
        wait_cycles(2);
        check("restart_drop", drop_count, 16'd3);
        check("restart_commit", commited_wr_addr, 10'd27);
        check("restart_header", mem[18], 64'h00000040_00000000);

        // stray non-sof beat in IDLE
        send_beat({$urandom, $urandom}, 0, 0, 3'd0, 50, ok);
        wait_cycles(2);
        check("stray_drop", drop_count, 16'd4);

        // fill to the full boundary with the reader parked at 0
        stalls = 0;
        for (int f = 0; f < 54; f++) begin
            for (int b = 0; b < 8; b++) begin
                logic [63:0] d;
                d = {$urandom, $urandom};
                send_beat(d, b == 0, b == 7, 3'd0, 40, ok);
                if (!ok) begin
                    stalls++;
                    check("full_commit", commited_wr_addr, 10'd504);
                    check("full_ready", in_ready, 0);
                    rd = 10'd18;
                    send_beat(d, b == 0, b == 7, 3'd0, 40, ok);
                    check("full_resume", ok, 1);
                end
            end
        end
        wait_cycles(2);
        check("full_stalls", stalls, 1);
        check("full_final_commit", commited_wr_addr, 10'd513);

        // randomized traffic with a reader trailing the commit pointer
        rd_follow = 1;
        gap_max = 2;
        for (int f = 0; f < 150; f++) begin
            int n;
            n = ($urandom_range(0, 24) == 0) ? $urandom_range(257, 262) : $urandom_range(1, 24);
            if ($urandom_range(0, 19) == 0) begin
                send_beat({$urandom, $urandom}, 0, 1'($urandom_range(0, 1)), 3'd0, 2000, ok);
                if (!ok) check("rand_timeout", 0, 1);
            end
            for (int i = 0; i < n; i++) begin
                send_beat({$urandom, $urandom}, (i == 0) || ($urandom_range(0, 40) == 0),
                          i == n - 1, 3'($urandom_range(0, 7)), 2000, ok);
                if (!ok) check("rand_timeout", 0, 1);
            end
        end
        wait_cycles(4);
        check("wrap_seen", wraps >= 1, 1);

        // asynchronous reset mid-frame
        rd_follow = 0;
        for (int b = 0; b < 3; b++) send_beat({$urandom, $urandom}, b == 0, 0, 3'd0, 2000, ok);
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_commit", commited_wr_addr, 0);
        check("arst_drop", drop_count, 0);
        rd = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        send_frame(8, 3'd0, "post_rst");
        wait_cycles(2);
        check("post_rst_commit", commited_wr_addr, 10'd9);
        check("post_rst_header", mem[0], 64'h00000040_00000000);
        wait_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
